// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receive-side and consumer-side signal bundle for uart_rx_fifo
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 4
);
  // uart_recv side
  logic [7:0]      rx_data;
  logic            rx_busy;
  logic            rx_okay;

  // consumer side
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready;

  // status and control
  logic [ADDR_W:0] count;
  logic            full;
  logic            overflow;
  logic            frame_err;
  logic            err_clear;

  modport master (
    output rx_data, rx_busy, rx_okay, out_ready, err_clear,
    input  out_data, out_valid, count, full, overflow, frame_err
  );

  modport slave (
    input  rx_data, rx_busy, rx_okay, out_ready, err_clear,
    output out_data, out_valid, count, full, overflow, frame_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - frame-detecting byte FIFO behind uart_recv with sticky error flags
module uart_rx_fifo #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic           CLK100MHZ,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] count_q;
  logic            busy_d;
  logic            overflow_q;
  logic            frame_err_q;

  logic            done;
  logic            push_req;
  logic            bad_frame;
  logic            is_full;
  logic            is_empty;
  logic            pop;
  logic            push;
  logic            drop;

  // The falling edge of rx_busy marks exactly one completed frame; data and
  // okay are valid from uart_recv in that same cycle.
  assign done      = busy_d & ~bus.rx_busy;
  assign push_req  = done & bus.rx_okay;
  assign bad_frame = done & ~bus.rx_okay;

  assign is_full   = (count_q == DEPTH_C);
  assign is_empty  = (count_q == '0);

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a
  // byte when the consumer drains concurrently.
  assign pop       = ~is_empty & bus.out_ready;
  assign push      = push_req & (~is_full | pop);
  assign drop      = push_req & is_full & ~pop;

  // Edge-detect register for rx_busy.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      busy_d <= 1'b0;
    end else begin
      busy_d <= bus.rx_busy;
    end
  end

  // Storage array is deliberately left unreset; only the pointers define contents.
  always_ff @(posedge CLK100MHZ) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= bus.rx_data;
    end
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (bus.err_clear) begin
        overflow_q <= 1'b0;
      end
      if (bad_frame) begin
        frame_err_q <= 1'b1;
      end else if (bus.err_clear) begin
        frame_err_q <= 1'b0;
      end
    end
  end

  // Show-ahead head byte; every output depends only on registers or the array.
  assign bus.out_data  = mem[rd_ptr[ADDR_W-1:0]];
  assign bus.out_valid = ~is_empty;
  assign bus.count     = count_q;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;

  // Pointer MSBs only record the wrap lap; occupancy comes from count_q.
  logic unused_ptr_msb;
  assign unused_ptr_msb = &{1'b0, wr_ptr[ADDR_W], rd_ptr[ADDR_W]};

endmodule
